// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and widths for the FIFO drain-side UART transmitter.
//   tx_state_t : frame FSM states
//   DATA_W     : FIFO word / UART character width
//   CNT_W      : width of the completed-frame counter
package fifo_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period timer for the UART transmitter.
//   CLOCK      in  system clock, rising edge
//   RESET_N    in  asynchronous active-low reset
//   load_i     in  restart the bit period on the next edge
//   bit_done_o out high during the last cycle of each bit period
// The counter free-runs, reloading itself at zero, so after a load it marks
// every CLKS_PER_BIT-th cycle without further help from the FSM.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic load_i,
  output logic bit_done_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (load_i || (cnt_q == '0)) cnt_d = RELOAD;
    else                         cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bit_done_o = (cnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a show-ahead FIFO and sends each as a UART
// frame (start, 8 data bits LSB first, optional even parity, stop).
//   CLOCK      in  system clock, rising edge
//   RESET_N    in  asynchronous active-low reset
//   ENABLE     in  allow new frames to start
//   F_EMPTY_N  in  FIFO not-empty flag
//   FIFO_DATA  in  FIFO head word
//   READ       out one-cycle pop strobe
//   TX         out serial line (idle high)
//   BUSY       out frame in progress
//   TX_COUNT   out frames completed since reset (wrapping)
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              F_EMPTY_N,
  input  logic [DATA_W-1:0] FIFO_DATA,
  output logic              READ,
  output logic              TX,
  output logic              BUSY,
  output logic [CNT_W-1:0]  TX_COUNT
);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        idx_q, idx_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              baud_load;
  logic              bit_done;
  logic              do_latch;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .load_i     (baud_load),
    .bit_done_o (bit_done)
  );

  // A new byte is taken either from idle or on the last stop cycle, which
  // makes back-to-back frames gapless.
  assign do_latch = ENABLE && F_EMPTY_N &&
                    ((state_q == IDLE) || ((state_q == STOP) && bit_done));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    par_d     = par_q;
    tx_d      = tx_q;
    read_d    = 1'b0;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    baud_load = 1'b0;

    case (state_q)
      IDLE: ;
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          par_d = par_q ^ shift_q[0];
          if (idx_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q ^ shift_q[0];
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // Next bit is shift_q[1]; drive it now so TX stays registered.
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_latch) begin
      shift_d   = FIFO_DATA;
      read_d    = 1'b1;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      par_d     = 1'b0;
      idx_d     = 3'd0;
      baud_load = 1'b1;
      state_d   = START;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign READ     = read_q;
  assign TX       = tx_q;
  assign BUSY     = busy_q;
  assign TX_COUNT = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: one instance without parity (dut0) and one with
// even parity (dut1), each fed by its own show-ahead FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst0_n, rst1_n, en0, en1;

  // FIFO models
  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
  logic empty_n0, empty_n1;
  logic [7:0] data0, data1;
  assign empty_n0 = (wp0 != rp0);
  assign empty_n1 = (wp1 != rp1);
  assign data0 = mem0[rp0[5:0]];
  assign data1 = mem1[rp1[5:0]];

  logic read0, tx0, busy0, read1, tx1, busy1;
  logic [15:0] cnt0, cnt1;

  always @(posedge clk) if (read0 && empty_n0) rp0 <= rp0 + 1;
  always @(posedge clk) if (read1 && empty_n1) rp1 <= rp1 + 1;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
    .CLOCK(clk), .RESET_N(rst0_n), .ENABLE(en0), .F_EMPTY_N(empty_n0),
    .FIFO_DATA(data0), .READ(read0), .TX(tx0), .BUSY(busy0), .TX_COUNT(cnt0));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
    .CLOCK(clk), .RESET_N(rst1_n), .ENABLE(en1), .F_EMPTY_N(empty_n1),
    .FIFO_DATA(data1), .READ(read1), .TX(tx1), .BUSY(busy1), .TX_COUNT(cnt1));

  logic sel = 1'b0;
  logic tx_m, busy_m, read_m;
  logic [15:0] cnt_m;
  always_comb begin
    tx_m   = sel ? tx1   : tx0;
    busy_m = sel ? busy1 : busy0;
    read_m = sel ? read1 : read0;
    cnt_m  = sel ? cnt1  : cnt0;
  end

  int checks = 0;
  int passes = 0;
  int exp_cnt [2] = '{0, 0};
  logic [7:0] exp_q [$];

  // Reference: frame slot 0 = start, 1..8 = data LSB first,
  // 9 = even parity when enabled, everything else = stop (1).
  function automatic logic exp_bit(input logic [7:0] b, input int par, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && par != 0) return ^b;
    return 1'b1;
  endfunction

  task automatic push(input int s, input logic [7:0] b);
    if (s == 0) begin mem0[wp0[5:0]] = b; wp0++; end
    else        begin mem1[wp1[5:0]] = b; wp1++; end
  endtask

  // Expects nframes frames from DUT s, compared cycle by cycle with the
  // bytes queued in exp_q. drop_k >= 0 clears ENABLE at that cycle of frame 0.
  task automatic run_and_check(input int s, input string name, input int nframes, input int drop_k);
    int waited = 0;
    int flen;
    logic [7:0] b;
    sel = (s != 0);
    #1;
    while (tx_m !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (tx_m !== 1'b0) begin
      checks++;
      $display("FAIL %s start: no start bit within 100 cycles (tx=%b, want 0)", name, tx_m);
      return;
    end
    flen = (10 + s) * CPB;
    for (int f = 0; f < nframes; f++) begin
      b = exp_q.pop_front();
      for (int k = 0; k < flen; k++) begin
        checks++;
        if (tx_m !== exp_bit(b, s, k / CPB))
          $display("FAIL %s tx frame %0d byte %h cycle %0d: got %b want %b", name, f, b, k, tx_m, exp_bit(b, s, k / CPB));
        else passes++;
        checks++;
        if (busy_m !== 1'b1)
          $display("FAIL %s busy frame %0d cycle %0d: got %b want 1", name, f, k, busy_m);
        else passes++;
        checks++;
        if (read_m !== (k == 0))
          $display("FAIL %s read frame %0d cycle %0d: got %b want %b", name, f, k, read_m, (k == 0));
        else passes++;
        if (f == 0 && k == drop_k) begin
          if (s == 0) en0 = 1'b0; else en1 = 1'b0;
        end
        @(negedge clk);
      end
    end
    exp_cnt[s] += nframes;
    checks++;
    if (tx_m !== 1'b1 || busy_m !== 1'b0 || read_m !== 1'b0)
      $display("FAIL %s idle after frames: tx=%b busy=%b read=%b want 1/0/0", name, tx_m, busy_m, read_m);
    else passes++;
    checks++;
    if (cnt_m !== exp_cnt[s][15:0])
      $display("FAIL %s tx_count: got %0d want %0d", name, cnt_m, exp_cnt[s]);
    else passes++;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0; rst1_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s != 0);
      #1;
      checks++;
      if (tx_m !== 1'b1) $display("FAIL reset tx dut%0d: got %b want 1", s, tx_m); else passes++;
      checks++;
      if (read_m !== 1'b0) $display("FAIL reset read dut%0d: got %b want 0", s, read_m); else passes++;
      checks++;
      if (busy_m !== 1'b0) $display("FAIL reset busy dut%0d: got %b want 0", s, busy_m); else passes++;
      checks++;
      if (cnt_m !== 16'd0) $display("FAIL reset count dut%0d: got %0d want 0", s, cnt_m); else passes++;
    end
    @(negedge clk);
    rst0_n = 1'b1; rst1_n = 1'b1;
    sel = 1'b0;
    push(0, 8'hA5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (read_m !== 1'b0 || tx_m !== 1'b1)
        $display("FAIL hold cycle %0d: read=%b tx=%b want 0/1", i, read_m, tx_m);
      else passes++;
    end
    checks++;
    if (wp0 - rp0 !== 1) $display("FAIL hold fifo level: got %0d want 1", wp0 - rp0); else passes++;
  endtask

  task automatic test_single();
    exp_q.push_back(8'hA5);
    en0 = 1'b1;
    run_and_check(0, "single", 1, -1);
  endtask

  task automatic test_back_to_back();
    push(0, 8'h00); push(0, 8'hFF);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    run_and_check(0, "b2b", 2, -1);
    checks++;
    if (empty_n0 !== 1'b0) $display("FAIL b2b empty flag: got %b want 0", empty_n0); else passes++;
  endtask

  task automatic test_parity();
    en1 = 1'b1;
    push(1, 8'h07); push(1, 8'h03);
    exp_q.push_back(8'h07); exp_q.push_back(8'h03);
    run_and_check(1, "parity", 2, -1);
  endtask

  task automatic test_enable_drop();
    push(0, 8'h5A); push(0, 8'h3C); push(0, 8'h81);
    exp_q.push_back(8'h5A);
    run_and_check(0, "endrop", 1, 13);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (read0 !== 1'b0 || tx0 !== 1'b1)
        $display("FAIL endrop quiet cycle %0d: read=%b tx=%b want 0/1", i, read0, tx0);
      else passes++;
    end
    checks++;
    if (wp0 - rp0 !== 2) $display("FAIL endrop fifo level: got %0d want 2", wp0 - rp0); else passes++;
  endtask

  task automatic test_reset_midframe();
    int waited = 0;
    sel = 1'b0;
    en0 = 1'b1;
    @(negedge clk);
    while (tx0 !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tx0 !== 1'b0) $display("FAIL rstmid start: tx=%b want 0", tx0); else passes++;
    repeat (17) @(negedge clk);
    #3 rst0_n = 1'b0;
    #1;
    exp_cnt[0] = 0;
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || read0 !== 1'b0)
      $display("FAIL rstmid async: tx=%b busy=%b read=%b want 1/0/0", tx0, busy0, read0);
    else passes++;
    checks++;
    if (cnt0 !== 16'd0) $display("FAIL rstmid count: got %0d want 0", cnt0); else passes++;
    checks++;
    if (wp0 - rp0 !== 1) $display("FAIL rstmid fifo level: got %0d want 1", wp0 - rp0); else passes++;
    @(negedge clk);
    rst0_n = 1'b1;
    exp_q.push_back(8'h81);
    run_and_check(0, "after_rst", 1, -1);
  endtask

  task automatic test_random();
    int n;
    logic [7:0] b;
    for (int s = 0; s < 2; s++) begin
      n = $urandom_range(3, 5);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        push(s, b);
        exp_q.push_back(b);
      end
      run_and_check(s, "random", n, -1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_enable_drop();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
